cam_reg_init_seq: RTL and testbench



---
 rtl/cam_reg_init_seq.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cam_reg_init_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_reg_init_seq.sv
// rtl/cam_reg_init_seq.sv - camera register table walker driving the I2C byte driver
//
// Walks a {reg[15:0], data[7:0]} table held in an external ROM and issues one
// I2C write per entry. Two reserved register codes are interpreted locally:
//   16'hFFFF  delay entry: wait data * DELAY_UNIT cycles
//   16'hFFFE  end marker: finish the sequence early
// Failed transactions (ACK error or busy never rising) are re-issued up to
// MAX_RETRY times before the sequence stops in FAIL.
//
// Optional feature macro: CAM_INIT_VERIFY_EN
//   When defined, every successful write is read back and compared; a
//   mismatch consumes a retry. Adds the verify_err_cnt output.
//
// Ports:
//   clk_i, rst_n        clock, asynchronous active-low reset
//   start               rising edge in IDLE/DONE/FAIL begins a sequence
//   rom_addr, rom_data  table index out, entry back one cycle later
//   i2c_*               exclusive handshake with the I2C byte driver
//   done, fail          sticky completion flags, cleared by the next start
//   fail_idx            index of the entry that exhausted its retries
//   running             high from start edge until done or fail
//   verify_err_cnt      saturating readback mismatch count (verify build only)

module cam_reg_init_seq #(
    parameter int         NUM_ENTRIES  = 64,
    parameter int         IDX_W        = 8,
    parameter logic [7:0] DEV_ADDR     = 8'h78,
    parameter int         PWRUP_CYCLES = 16000,
    parameter int         DELAY_UNIT   = 800,
    parameter int         MAX_RETRY    = 3,
    parameter int         BUSY_TO      = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [23:0]      rom_data,
    output logic             i2c_start_en,
    output logic             i2c_wr_rd_flag,
    output logic [7:0]       i2c_device_addr,
    output logic [15:0]      i2c_register,
    output logic [7:0]       i2c_data_byte,
    input  logic             i2c_busy,
    input  logic             i2c_err,
    input  logic [7:0]       i2c_rd_data,
    output logic             done,
    output logic             fail,
    output logic [IDX_W-1:0] fail_idx,
    output logic             running
`ifdef CAM_INIT_VERIFY_EN
    ,
    output logic [7:0]       verify_err_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_HI,
        S_WAIT_LO, S_CHECK, S_DELAY, S_DONE, S_FAIL, S_VERIFY
    } state_t;

    localparam logic [23:0]      LP_PWRUP_LAST = 24'(PWRUP_CYCLES - 1);
    localparam logic [23:0]      LP_BUSY_LAST  = 24'(BUSY_TO - 1);
    localparam logic [23:0]      LP_DELAY_UNIT = 24'(DELAY_UNIT);
    localparam logic [3:0]       LP_MAX_RETRY  = 4'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LP_LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] LP_IDX_ONE    = IDX_W'(1);

    state_t           r_state;
    logic             r_start_d;
    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_cnt;
    logic [3:0]       r_retry;
    logic             r_err_seen;
    logic             r_start_en;
    logic [15:0]      r_reg;
    logic [7:0]       r_data;
    logic             r_done;
    logic             r_fail;
    logic [IDX_W-1:0] r_fail_idx;
    logic             r_running;

    logic             w_start_rise;
    logic             w_last;
    logic [23:0]      w_delay_ld;
    state_t           w_post_xfer;

    assign w_start_rise = start & ~r_start_d;
    assign w_last       = (r_idx == LP_LAST_IDX);
    // 8-bit tick count scaled into the 24-bit delay counter
    assign w_delay_ld   = {16'd0, rom_data[7:0]} * LP_DELAY_UNIT;

`ifdef CAM_INIT_VERIFY_EN
    logic       r_phase;        // 0: write in flight, 1: readback in flight
    logic       r_wr_rd;
    logic [7:0] r_verify_cnt;
    assign w_post_xfer    = r_phase ? S_VERIFY : S_CHECK;
    assign i2c_wr_rd_flag = r_wr_rd;
    assign verify_err_cnt = r_verify_cnt;
`else
    logic w_unused_rd;
    assign w_unused_rd    = ^i2c_rd_data;
    assign w_post_xfer    = S_CHECK;
    assign i2c_wr_rd_flag = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_err_seen <= 1'b0;
            r_start_en <= 1'b0;
            r_reg      <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
            r_running  <= 1'b0;
`ifdef CAM_INIT_VERIFY_EN
            r_phase      <= 1'b0;
            r_wr_rd      <= 1'b0;
            r_verify_cnt <= '0;
`endif
        end else begin
            r_start_d  <= start;
            r_start_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_start_rise) begin
                        r_state    <= S_PWRUP;
                        r_done     <= 1'b0;
                        r_fail     <= 1'b0;
                        r_fail_idx <= '0;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_retry    <= '0;
                        r_err_seen <= 1'b0;
                        r_running  <= 1'b1;
`ifdef CAM_INIT_VERIFY_EN
                        r_phase      <= 1'b0;
                        r_wr_rd      <= 1'b0;
                        r_verify_cnt <= '0;
`endif
                    end
                end
                S_PWRUP: begin
                    if (r_cnt == LP_PWRUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                // rom_addr follows r_idx; the entry is on rom_data in DECODE
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (rom_data[23:8] == 16'hFFFF) begin
                        r_cnt   <= w_delay_ld;
                        r_state <= S_DELAY;
                    end else if (rom_data[23:8] == 16'hFFFE) begin
                        r_done    <= 1'b1;
                        r_running <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (!i2c_busy) begin
                        // start pulse goes out in ISSUE with reg/data already settled
                        r_reg      <= rom_data[23:8];
                        r_data     <= rom_data[7:0];
                        r_retry    <= '0;
                        r_start_en <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt      <= '0;
                    r_err_seen <= 1'b0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i2c_busy) begin
                        r_err_seen <= i2c_err;
                        r_state    <= S_WAIT_LO;
                    end else if (r_cnt == LP_BUSY_LAST) begin
                        // driver never acknowledged the start: same path as a NACK
                        r_err_seen <= 1'b1;
                        r_state    <= w_post_xfer;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (i2c_busy) begin
                        r_err_seen <= r_err_seen | i2c_err;
                    end else begin
                        r_state <= w_post_xfer;
                    end
                end
                S_CHECK: begin
                    if (i2c_busy) begin
                        r_state <= S_CHECK;
                    end else if (!r_err_seen) begin
`ifdef CAM_INIT_VERIFY_EN
                        r_phase    <= 1'b1;
                        r_wr_rd    <= 1'b1;
                        r_start_en <= 1'b1;
                        r_state    <= S_ISSUE;
`else
                        if (w_last) begin
                            r_done    <= 1'b1;
                            r_running <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + LP_IDX_ONE;
                            r_state <= S_FETCH;
                        end
`endif
                    end else if (r_retry < LP_MAX_RETRY) begin
                        r_retry    <= r_retry + 4'd1;
                        r_start_en <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_fail_idx <= r_idx;
                        r_fail     <= 1'b1;
                        r_running  <= 1'b0;
                        r_state    <= S_FAIL;
                    end
                end
`ifdef CAM_INIT_VERIFY_EN
                S_VERIFY: begin
                    if (i2c_busy) begin
                        r_state <= S_VERIFY;
                    end else begin
                        r_phase <= 1'b0;
                        r_wr_rd <= 1'b0;
                        if (!r_err_seen && (i2c_rd_data == r_data)) begin
                            if (w_last) begin
                                r_done    <= 1'b1;
                                r_running <= 1'b0;
                                r_state   <= S_DONE;
                            end else begin
                                r_idx   <= r_idx + LP_IDX_ONE;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            if (r_verify_cnt != 8'hFF) begin
                                r_verify_cnt <= r_verify_cnt + 8'd1;
                            end
                            if (r_retry < LP_MAX_RETRY) begin
                                // re-issue the write, not the read
                                r_retry    <= r_retry + 4'd1;
                                r_start_en <= 1'b1;
                                r_state    <= S_ISSUE;
                            end else begin
                                r_fail_idx <= r_idx;
                                r_fail     <= 1'b1;
                                r_running  <= 1'b0;
                                r_state    <= S_FAIL;
                            end
                        end
                    end
                end
`endif
                S_DELAY: begin
                    if (r_cnt == 24'd0) begin
                        if (w_last) begin
                            r_done    <= 1'b1;
                            r_running <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + LP_IDX_ONE;
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr        = r_idx;
    assign i2c_start_en    = r_start_en;
    assign i2c_device_addr = DEV_ADDR;
    assign i2c_register    = r_reg;
    assign i2c_data_byte   = r_data;
    assign done            = r_done;
    assign fail            = r_fail;
    assign fail_idx        = r_fail_idx;
    assign running         = r_running;

endmodule

// File: tb/tb_cam_reg_init_seq.sv
// tb/tb_cam_reg_init_seq.sv - self-checking bench for cam_reg_init_seq
module tb_cam_reg_init_seq;

    localparam int NUM_ENTRIES = 4;
    localparam int IDX_W       = 8;
    localparam int PWRUP       = 20;
    localparam int DUNIT       = 800;
    localparam int MAXR        = 3;
    localparam int BTO         = 8;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] rom_addr;
    logic [23:0]      rom_data = '0;
    logic             i2c_start_en;
    logic             i2c_wr_rd_flag;
    logic [7:0]       i2c_device_addr;
    logic [15:0]      i2c_register;
    logic [7:0]       i2c_data_byte;
    logic             i2c_busy = 1'b0;
    logic             i2c_err = 1'b0;
    logic [7:0]       i2c_rd_data = '0;
    logic             done;
    logic             fail;
    logic [IDX_W-1:0] fail_idx;
    logic             running;
`ifdef CAM_INIT_VERIFY_EN
    logic [7:0]       verify_err_cnt;
`endif

    cam_reg_init_seq #(
        .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .DEV_ADDR(8'h78),
        .PWRUP_CYCLES(PWRUP), .DELAY_UNIT(DUNIT), .MAX_RETRY(MAXR), .BUSY_TO(BTO)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_start_en(i2c_start_en), .i2c_wr_rd_flag(i2c_wr_rd_flag),
        .i2c_device_addr(i2c_device_addr), .i2c_register(i2c_register),
        .i2c_data_byte(i2c_data_byte), .i2c_busy(i2c_busy), .i2c_err(i2c_err),
        .i2c_rd_data(i2c_rd_data), .done(done), .fail(fail),
        .fail_idx(fail_idx), .running(running)
`ifdef CAM_INIT_VERIFY_EN
        , .verify_err_cnt(verify_err_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ROM with one cycle of read latency
    logic [23:0] rom [0:NUM_ENTRIES-1];
    always @(posedge clk_i)
        rom_data <= (rom_addr < NUM_ENTRIES) ? rom[rom_addr] : 24'hFFFE00;

    // I2C driver model: 7-cycle busy window, optional NACK on one register
    logic [15:0] cfg_nack_reg   = 16'h0000;
    int          cfg_nack_times = 0;
    bit          cfg_busy_never = 1'b0;
    bit          cfg_rd_force   = 1'b0;
    logic [7:0]  cfg_rd_value   = 8'h00;
    int          d_cnt;
    int          d_hits;
    logic        d_nack;
    logic [7:0]  d_last_w = 8'h00;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            i2c_busy <= 1'b0;
            i2c_err  <= 1'b0;
            d_cnt    <= 0;
            d_hits   <= 0;
            d_nack   <= 1'b0;
        end else if (!i2c_busy) begin
            i2c_err <= 1'b0;
            if (i2c_start_en && !cfg_busy_never) begin
                i2c_busy <= 1'b1;
                d_cnt    <= 6;
                d_nack   <= (i2c_register == cfg_nack_reg) && (d_hits < cfg_nack_times);
                if (i2c_register == cfg_nack_reg) d_hits <= d_hits + 1;
                if (i2c_wr_rd_flag) i2c_rd_data <= cfg_rd_force ? cfg_rd_value : d_last_w;
                else d_last_w <= i2c_data_byte;
            end
        end else begin
            i2c_err <= d_nack && (d_cnt == 3);
            if (d_cnt == 0) begin
                i2c_busy <= 1'b0;
                i2c_err  <= 1'b0;
            end else begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    // Monitor: records every start pulse and every busy fall
    typedef struct packed { logic rw; logic [15:0] rg; logic [7:0] dt; } xact_t;
    xact_t obs      [0:255];
    logic  obs_busy [0:255];
    int    obs_cyc  [0:255];
    int    obs_n  = 0;
    int    fall_cyc [0:255];
    int    fall_n = 0;
    int    cyc    = 0;
    logic  prev_busy = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (i2c_start_en && obs_n < 256) begin
            obs[obs_n]      <= '{i2c_wr_rd_flag, i2c_register, i2c_data_byte};
            obs_busy[obs_n] <= i2c_busy;
            obs_cyc[obs_n]  <= cyc;
            obs_n           <= obs_n + 1;
        end
        if (prev_busy && !i2c_busy && fall_n < 256) begin
            fall_cyc[fall_n] <= cyc;
            fall_n           <= fall_n + 1;
        end
        prev_busy <= i2c_busy;
    end

    // Scoreboard of expected start pulses
    xact_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic push_w(input logic [15:0] rg, input logic [7:0] dt);
        exp_q.push_back('{1'b0, rg, dt});
    endtask

    // write plus, in the verify build, its readback
    task automatic push_wr(input logic [15:0] rg, input logic [7:0] dt);
        exp_q.push_back('{1'b0, rg, dt});
`ifdef CAM_INIT_VERIFY_EN
        exp_q.push_back('{1'b1, rg, dt});
`endif
    endtask

    task automatic apply_reset();
        start          = 1'b0;
        rst_n          = 1'b0;
        cfg_nack_times = 0;
        cfg_busy_never = 1'b0;
        cfg_rd_force   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic run_seq(input int max_cyc, output bit timed_out);
        @(negedge clk_i); start = 1'b1;
        @(negedge clk_i); @(negedge clk_i); start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            if (done || fail) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({done, fail, running, i2c_start_en, i2c_wr_rd_flag} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 00000", {done, fail, running, i2c_start_en, i2c_wr_rd_flag});
        end
        n_checks++;
        if ({i2c_register, i2c_data_byte, rom_addr, fail_idx} !== 40'h0) begin
            n_errors++;
            $display("FAIL reset_buses: got %h want 0", {i2c_register, i2c_data_byte, rom_addr, fail_idx});
        end
        n_checks++;
        if (i2c_device_addr !== 8'h78) begin
            n_errors++;
            $display("FAIL reset_devaddr: got %h want 78", i2c_device_addr);
        end
    endtask

    task automatic test_three_writes();
        bit to; int k; int fb; xact_t e;
        apply_reset();
        rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'h3017_FF; rom[3] = 24'hFFFE_00;
        push_wr(16'h3008, 8'h82); push_wr(16'h3103, 8'h03); push_wr(16'h3017, 8'hFF);
        k = obs_n; fb = fall_n;
        run_seq(5000, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL three_writes_timeout: done/fail never rose"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (k >= obs_n || obs[k] !== e || obs_busy[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL three_writes_pulse%0d: got %h busy %b want %h busy 0", k, obs[k], obs_busy[k], e);
            end
            k++;
        end
        n_checks++;
        if (obs_n !== k) begin n_errors++; $display("FAIL three_writes_count: got %0d pulses want %0d", obs_n, k); end
        n_checks++;
        if ({done, fail, running} !== 3'b100) begin
            n_errors++; $display("FAIL three_writes_flags: got %b want 100", {done, fail, running});
        end
        n_checks++;
`ifdef CAM_INIT_VERIFY_EN
        if (fall_n - fb !== 6) begin n_errors++; $display("FAIL three_writes_falls: got %0d want 6", fall_n - fb); end
`else
        if (fall_n - fb !== 3) begin n_errors++; $display("FAIL three_writes_falls: got %0d want 3", fall_n - fb); end
`endif
    endtask

    task automatic test_delay();
        bit to; int k; int fb; int gap;
        apply_reset();
        rom[0] = 24'h3008_02; rom[1] = 24'hFFFF_02; rom[2] = 24'h4300_30; rom[3] = 24'hFFFE_00;
        k = obs_n; fb = fall_n;
        run_seq(5000, to);
`ifdef CAM_INIT_VERIFY_EN
        gap = obs_cyc[k + 2] - fall_cyc[fb + 1];
`else
        gap = obs_cyc[k + 1] - fall_cyc[fb];
`endif
        n_checks++;
        if (to || gap < 2 * DUNIT) begin
            n_errors++; $display("FAIL delay_gap: got %0d cycles (timeout %0b) want >= %0d", gap, to, 2 * DUNIT);
        end
        n_checks++;
        if (done !== 1'b1 || obs[k + (obs_n - k - 1)].rg !== 16'h4300) begin
            n_errors++; $display("FAIL delay_done: got done %b last reg %h want 1 4300", done, obs[obs_n - 1].rg);
        end
    endtask

    task automatic test_nack_retry();
        bit to; int k; xact_t e;
        apply_reset();
        rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'h3017_FF; rom[3] = 24'hFFFE_00;
        cfg_nack_reg = 16'h3008; cfg_nack_times = 2;
        push_w(16'h3008, 8'h82); push_w(16'h3008, 8'h82);
        push_wr(16'h3008, 8'h82); push_wr(16'h3103, 8'h03); push_wr(16'h3017, 8'hFF);
        k = obs_n;
        run_seq(5000, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (k >= obs_n || obs[k] !== e) begin
                n_errors++; $display("FAIL nack_retry_pulse%0d: got %h want %h", k, obs[k], e);
            end
            k++;
        end
        n_checks++;
        if (to || obs_n !== k || {done, fail} !== 2'b10) begin
            n_errors++; $display("FAIL nack_retry_end: got pulses %0d done %b fail %b want %0d 1 0", obs_n, done, fail, k);
        end
    endtask

    task automatic test_nack_fail();
        bit to; int k; int n_at_fail; xact_t e;
        apply_reset();
        rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'h3017_FF; rom[3] = 24'h3018_11;
        cfg_nack_reg = 16'h3017; cfg_nack_times = 1000;
        push_wr(16'h3008, 8'h82); push_wr(16'h3103, 8'h03);
        for (int i = 0; i <= MAXR; i++) push_w(16'h3017, 8'hFF);
        k = obs_n;
        run_seq(5000, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (k >= obs_n || obs[k] !== e) begin
                n_errors++; $display("FAIL nack_fail_pulse%0d: got %h want %h", k, obs[k], e);
            end
            k++;
        end
        n_checks++;
        if (to || {done, fail, running} !== 3'b010 || fail_idx !== 8'd2) begin
            n_errors++; $display("FAIL nack_fail_flags: got d%b f%b r%b idx %0d want 0 1 0 idx 2", done, fail, running, fail_idx);
        end
        n_at_fail = obs_n;
        repeat (30) @(negedge clk_i);
        n_checks++;
        if (rom_addr !== 8'd2 || obs_n !== n_at_fail || obs_n !== k) begin
            n_errors++; $display("FAIL nack_fail_hold: got addr %0d pulses %0d want addr 2 pulses %0d", rom_addr, obs_n, k);
        end
    endtask

    task automatic test_busy_timeout();
        bit to; int k; int sp;
        apply_reset();
        rom[0] = 24'h3008_82; rom[1] = 24'hFFFE_00; rom[2] = 24'hFFFE_00; rom[3] = 24'hFFFE_00;
        cfg_busy_never = 1'b1;
        k = obs_n;
        run_seq(5000, to);
        n_checks++;
        if (to || obs_n - k !== MAXR + 1 || {fail, done} !== 2'b10 || fail_idx !== 8'd0) begin
            n_errors++; $display("FAIL busy_to_end: got pulses %0d fail %b done %b idx %0d want %0d 1 0 0", obs_n - k, fail, done, fail_idx, MAXR + 1);
        end
        for (int i = k + 1; i < obs_n; i++) begin
            sp = obs_cyc[i] - obs_cyc[i - 1];
            n_checks++;
            if (sp < BTO || sp > BTO + 4 || obs[i] !== xact_t'({1'b0, 16'h3008, 8'h82})) begin
                n_errors++; $display("FAIL busy_to_spacing%0d: got %0d cycles %h want %0d..%0d", i, sp, obs[i], BTO, BTO + 4);
            end
        end
    endtask

    // full table without end marker, last entry a zero delay, then restart from DONE
    task automatic test_back_to_back();
        bit to; int k; xact_t e;
        apply_reset();
        rom[0] = 24'h0100_01; rom[1] = 24'h0200_02; rom[2] = 24'h0300_03; rom[3] = 24'hFFFF_00;
        for (int run = 0; run < 2; run++) begin
            push_wr(16'h0100, 8'h01); push_wr(16'h0200, 8'h02); push_wr(16'h0300, 8'h03);
            k = obs_n;
            @(negedge clk_i); start = 1'b1;
            @(negedge clk_i); start = 1'b0;
            n_checks++;
            if ({running, done} !== 2'b10) begin
                n_errors++; $display("FAIL b2b_start%0d: got running %b done %b want 1 0", run, running, done);
            end
            // edges while running must be ignored
            repeat (PWRUP + 10) @(negedge clk_i);
            start = 1'b1; @(negedge clk_i); start = 1'b0;
            to = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk_i);
                if (done || fail) begin to = 1'b0; break; end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (k >= obs_n || obs[k] !== e) begin
                    n_errors++; $display("FAIL b2b_pulse%0d: got %h want %h", k, obs[k], e);
                end
                k++;
            end
            repeat (PWRUP + 5) @(negedge clk_i);
            n_checks++;
            if (to || obs_n !== k || {done, fail, running} !== 3'b100 || rom_addr !== 8'd3) begin
                n_errors++; $display("FAIL b2b_end%0d: got pulses %0d d%b f%b r%b addr %0d want %0d 1 0 0 addr 3", run, obs_n, done, fail, running, rom_addr, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'hFFFE_00; rom[3] = 24'hFFFE_00;
        @(negedge clk_i); start = 1'b1;
        @(negedge clk_i); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            if (i2c_busy) begin seen = 1'b1; break; end
        end
        @(negedge clk_i);
        n_checks++;
        if (!seen || running !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_setup: got busy_seen %b running %b want 1 1", seen, running);
        end
        rst_n = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({done, fail, running, i2c_start_en, i2c_wr_rd_flag, i2c_busy} !== 6'b0 ||
            {i2c_register, i2c_data_byte, rom_addr, fail_idx} !== 40'h0 || i2c_device_addr !== 8'h78) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got flags %b buses %h dev %h want 0 0 78",
                     {done, fail, running, i2c_start_en, i2c_wr_rd_flag, i2c_busy},
                     {i2c_register, i2c_data_byte, rom_addr, fail_idx}, i2c_device_addr);
        end
        rst_n = 1'b1;
    endtask

`ifdef CAM_INIT_VERIFY_EN
    task automatic test_verify();
        bit to; int k; xact_t e;
        apply_reset();
        rom[0] = 24'h3008_AA; rom[1] = 24'hFFFE_00; rom[2] = 24'hFFFE_00; rom[3] = 24'hFFFE_00;
        cfg_rd_force = 1'b1; cfg_rd_value = 8'h55;
        for (int i = 0; i <= MAXR; i++) push_wr(16'h3008, 8'hAA);
        k = obs_n;
        run_seq(5000, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (k >= obs_n || obs[k] !== e) begin
                n_errors++; $display("FAIL verify_pulse%0d: got %h want %h", k, obs[k], e);
            end
            k++;
        end
        n_checks++;
        if (to || obs_n !== k || fail !== 1'b1 || fail_idx !== 8'd0 || verify_err_cnt !== 8'(MAXR + 1)) begin
            n_errors++; $display("FAIL verify_end: got pulses %0d fail %b idx %0d cnt %0d want %0d 1 0 %0d", obs_n, fail, fail_idx, verify_err_cnt, k, MAXR + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_three_writes();
        test_delay();
        test_nack_retry();
        test_nack_fail();
        test_busy_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef CAM_INIT_VERIFY_EN
        test_verify();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
